// File: rtl/chirp_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : chirp_seq_pkg
//  Purpose  : Shared state encodings, field selects and reset defaults for the
//             chirp profile sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package chirp_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_ARMED   = 3'd2;
    localparam logic [2:0] ST_ADVANCE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [1:0] FIELD_CNT_MAX = 2'd0;
    localparam logic [1:0] FIELD_TUNE    = 2'd1;
    localparam logic [1:0] FIELD_FOFS    = 2'd2;

    localparam logic [31:0] DEF_CNT_MAX = 32'h0000_0FFF;
    localparam logic [31:0] DEF_TUNE    = 32'h0000_0001;
    localparam logic [31:0] DEF_FOFS    = 32'h0000_0600;

    // Profile packing: {freq_offset, tuning_coef, counter_max}
    localparam logic [95:0] DEF_PROFILE = {DEF_FOFS, DEF_TUNE, DEF_CNT_MAX};

endpackage
`default_nettype wire

// File: rtl/chirp_profile_table.sv
`default_nettype none
// ============================================================================
//  Module   : chirp_profile_table
//  Purpose  : Profile register file with field-decoded write port, async
//             96-bit profile read and optional registered readback
//             (CHIRP_SEQ_READBACK_EN).
//  Revision : 1.0  initial release
// ============================================================================
module chirp_profile_table
    import chirp_seq_pkg::*;
#(
    parameter int NUM_PROFILES = 8,
    parameter int ADDR_W       = 3
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [1:0]        wr_field_i,
    input  logic [31:0]       wr_data_i,
`ifdef CHIRP_SEQ_READBACK_EN
    input  logic [ADDR_W-1:0] rb_addr_i,
    input  logic [1:0]        rb_field_i,
    output logic [31:0]       rb_data_o,
`endif
    input  logic [ADDR_W-1:0] rd_idx_i,
    output logic [95:0]       rd_profile_o
);

    localparam logic [ADDR_W:0] ENTRY_LIMIT = (ADDR_W+1)'(NUM_PROFILES);

    logic [95:0] mem_q [NUM_PROFILES];
    logic        w_wr_ok;

    assign w_wr_ok = wr_en_i && ({1'b0, wr_addr_i} < ENTRY_LIMIT) && (wr_field_i != 2'd3);

    always_ff @(posedge aclk) begin
        for (int i = 0; i < NUM_PROFILES; i++) begin
            if (!aresetn) begin
                mem_q[i] <= DEF_PROFILE;
            end else if (w_wr_ok && (wr_addr_i == ADDR_W'(i))) begin
                case (wr_field_i)
                    FIELD_CNT_MAX: mem_q[i][31:0]  <= wr_data_i;
                    FIELD_TUNE:    mem_q[i][63:32] <= wr_data_i;
                    FIELD_FOFS:    mem_q[i][95:64] <= wr_data_i;
                    default:       ;
                endcase
            end
        end
    end

    always_comb begin
        rd_profile_o = '0;
        for (int i = 0; i < NUM_PROFILES; i++) begin
            if (rd_idx_i == ADDR_W'(i)) rd_profile_o = mem_q[i];
        end
    end

`ifdef CHIRP_SEQ_READBACK_EN
    logic [95:0] w_rb_profile;
    logic        w_rb_ok;
    logic [31:0] rb_data_q;

    assign w_rb_ok = ({1'b0, rb_addr_i} < ENTRY_LIMIT) && (rb_field_i != 2'd3);

    always_comb begin
        w_rb_profile = '0;
        for (int i = 0; i < NUM_PROFILES; i++) begin
            if (rb_addr_i == ADDR_W'(i)) w_rb_profile = mem_q[i];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn || !w_rb_ok) begin
            rb_data_q <= '0;
        end else begin
            case (rb_field_i)
                FIELD_CNT_MAX: rb_data_q <= w_rb_profile[31:0];
                FIELD_TUNE:    rb_data_q <= w_rb_profile[63:32];
                default:       rb_data_q <= w_rb_profile[95:64];
            endcase
        end
    end

    assign rb_data_o = rb_data_q;
`endif

endmodule
`default_nettype wire

// File: rtl/chirp_profile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : chirp_profile_sequencer
//  Purpose  : Steps the DAC chirp through a programmable profile table, one
//             profile per pulse. Optional readback: CHIRP_SEQ_READBACK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module chirp_profile_sequencer
    import chirp_seq_pkg::*;
#(
    parameter int NUM_PROFILES = 8,
    parameter int ADDR_W       = 3
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cfg_wr_en,
    input  logic [ADDR_W-1:0] cfg_wr_addr,
    input  logic [1:0]        cfg_wr_field,
    input  logic [31:0]       cfg_wr_data,
`ifdef CHIRP_SEQ_READBACK_EN
    input  logic [ADDR_W-1:0] cfg_rd_addr,
    input  logic [1:0]        cfg_rd_field,
    output logic [31:0]       cfg_rd_data,
`endif
    input  logic              seq_enable,
    input  logic              seq_loop,
    input  logic [ADDR_W-1:0] seq_last,
    input  logic              chirp_done,
    output logic [127:0]      chirp_parameters_out,
    output logic              params_valid,
    output logic [ADDR_W-1:0] profile_idx,
    output logic              seq_done,
    output logic [31:0]       sweep_count
);

    localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(NUM_PROFILES - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [127:0]      params_q, params_d;
    logic [31:0]       sweep_q, sweep_d;
    logic              hold_q, hold_d;
    logic [95:0]       w_table_profile;
    logic [ADDR_W-1:0] w_last;

    chirp_profile_table #(
        .NUM_PROFILES (NUM_PROFILES),
        .ADDR_W       (ADDR_W)
    ) u_table (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .wr_en_i      (cfg_wr_en),
        .wr_addr_i    (cfg_wr_addr),
        .wr_field_i   (cfg_wr_field),
        .wr_data_i    (cfg_wr_data),
`ifdef CHIRP_SEQ_READBACK_EN
        .rb_addr_i    (cfg_rd_addr),
        .rb_field_i   (cfg_rd_field),
        .rb_data_o    (cfg_rd_data),
`endif
        .rd_idx_i     (idx_q),
        .rd_profile_o (w_table_profile)
    );

    assign w_last = (seq_last > LAST_MAX) ? LAST_MAX : seq_last;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            params_q <= {32'h0, DEF_PROFILE};
            sweep_q  <= '0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            params_q <= params_d;
            sweep_q  <= sweep_d;
            hold_q   <= hold_d;
        end
    end

    // hold_q blocks an automatic restart after a single sweep until
    // seq_enable has been seen low.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        params_d = params_q;
        sweep_d  = sweep_q;
        hold_d   = hold_q && seq_enable;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (seq_enable && !hold_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!seq_enable) begin
                    state_d = ST_IDLE;
                end else begin
                    params_d = {32'h0, w_table_profile};
                    state_d  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (chirp_done) state_d = seq_enable ? ST_ADVANCE : ST_IDLE;
            end
            ST_ADVANCE: begin
                if (idx_q >= w_last) begin
                    sweep_d = sweep_q + 32'd1;
                    if (!seq_enable) begin
                        state_d = ST_IDLE;
                    end else if (seq_loop) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = seq_enable ? ST_LOAD : ST_IDLE;
                end
            end
            ST_DONE: begin
                hold_d  = seq_enable;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        params_valid         = (state_q == ST_ARMED);
        seq_done             = (state_q == ST_DONE);
        profile_idx          = idx_q;
        chirp_parameters_out = params_q;
        sweep_count          = sweep_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_chirp_profile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chirp_profile_sequencer
//  Purpose  : Scoreboard bench for chirp_profile_sequencer (8 profiles, 4-bit
//             index so out-of-range addresses are reachable).
//  Revision : 1.0  initial release
// ============================================================================
module tb_chirp_profile_sequencer;

    localparam int NUM_P = 8;
    localparam int AW    = 4;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic           cfg_wr_en;
    logic [AW-1:0]  cfg_wr_addr;
    logic [1:0]     cfg_wr_field;
    logic [31:0]    cfg_wr_data;
    logic           seq_enable;
    logic           seq_loop;
    logic [AW-1:0]  seq_last;
    logic           chirp_done;
    logic [127:0]   chirp_parameters_out;
    logic           params_valid;
    logic [AW-1:0]  profile_idx;
    logic           seq_done;
    logic [31:0]    sweep_count;
`ifdef CHIRP_SEQ_READBACK_EN
    logic [AW-1:0]  cfg_rd_addr = '0;
    logic [1:0]     cfg_rd_field = '0;
    logic [31:0]    cfg_rd_data;
`endif

    chirp_profile_sequencer #(
        .NUM_PROFILES (NUM_P),
        .ADDR_W       (AW)
    ) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .cfg_wr_en            (cfg_wr_en),
        .cfg_wr_addr          (cfg_wr_addr),
        .cfg_wr_field         (cfg_wr_field),
        .cfg_wr_data          (cfg_wr_data),
`ifdef CHIRP_SEQ_READBACK_EN
        .cfg_rd_addr          (cfg_rd_addr),
        .cfg_rd_field         (cfg_rd_field),
        .cfg_rd_data          (cfg_rd_data),
`endif
        .seq_enable           (seq_enable),
        .seq_loop             (seq_loop),
        .seq_last             (seq_last),
        .chirp_done           (chirp_done),
        .chirp_parameters_out (chirp_parameters_out),
        .params_valid         (params_valid),
        .profile_idx          (profile_idx),
        .seq_done             (seq_done),
        .sweep_count          (sweep_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [AW-1:0] idx;
        logic [127:0]  p;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [95:0] exp_tab [NUM_P];
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          done_cnt  = 0;
    int          cur_idx   = 0;
    int          exp_sweeps = 0;
    logic        pv_prev   = 1'b0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input int addr, input int field, input logic [31:0] data);
        cfg_wr_en    = 1'b1;
        cfg_wr_addr  = addr[AW-1:0];
        cfg_wr_field = field[1:0];
        cfg_wr_data  = data;
        tick();
        cfg_wr_en    = 1'b0;
        if (addr < NUM_P) begin
            case (field)
                0: exp_tab[addr][31:0]  = data;
                1: exp_tab[addr][63:32] = data;
                2: exp_tab[addr][95:64] = data;
                default: ;
            endcase
        end
    endtask

    task automatic push_expect(input int idx);
        exp_t x;
        x.idx = idx[AW-1:0];
        x.p   = {32'h0, exp_tab[idx]};
        sb.push_back(x);
    endtask

    task automatic pulse_done();
        chirp_done = 1'b1;
        tick();
        chirp_done = 1'b0;
    endtask

    task automatic wait_armed();
        int n = 0;
        while (params_valid !== 1'b1 && n < 32) begin
            tick();
            n++;
        end
        check_val("armed_wait", {127'h0, params_valid}, 128'h1);
    endtask

    task automatic wait_seq_done();
        int n = 0;
        while (seq_done !== 1'b1 && n < 32) begin
            tick();
            n++;
        end
        check_val("seq_done_wait", {127'h0, seq_done}, 128'h1);
    endtask

    task automatic start_seq();
        cur_idx = 0;
        push_expect(0);
        seq_enable = 1'b1;
        wait_armed();
    endtask

    // Ends the armed chirp and predicts the next armed profile.
    task automatic advance_chirp();
        int last;
        last = (int'(seq_last) > NUM_P - 1) ? NUM_P - 1 : int'(seq_last);
        if (cur_idx >= last) begin
            exp_sweeps++;
            cur_idx = seq_loop ? 0 : -1;
        end else begin
            cur_idx++;
        end
        if (cur_idx >= 0) push_expect(cur_idx);
        pulse_done();
        if (cur_idx >= 0) wait_armed();
    endtask

    always @(negedge aclk) begin
        if (params_valid && !pv_prev) begin
            if (sb.size() == 0) begin
                check_val("sb_underflow", 128'h1, 128'h0);
            end else begin
                e = sb.pop_front();
                check_val("arm_idx", {124'h0, profile_idx}, {124'h0, e.idx});
                check_val("arm_params", chirp_parameters_out, e.p);
            end
        end
        if (seq_done) done_cnt++;
        pv_prev = params_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_P; i++) exp_tab[i] = {32'h600, 32'h1, 32'hFFF};
        aresetn = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_field = '0;
        cfg_wr_data = '0; seq_enable = 1'b0; seq_loop = 1'b0; seq_last = '0;
        chirp_done = 1'b0;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();

        // Reset state
        check_val("rst_params", chirp_parameters_out, {32'h0, 32'h600, 32'h1, 32'hFFF});
        check_val("rst_valid", {127'h0, params_valid}, 128'h0);
        check_val("rst_sweep", {96'h0, sweep_count}, 128'h0);
        check_val("rst_idx", {124'h0, profile_idx}, 128'h0);
        check_val("rst_done", {127'h0, seq_done}, 128'h0);

        // Single sweep over profiles 0..2
        wr(0, 0, 32'h100);
        wr(1, 0, 32'h200);
        wr(2, 0, 32'h300);
        seq_last = 4'd2; seq_loop = 1'b0;
        cur_idx = 0;
        push_expect(0);
        seq_enable = 1'b1;
        tick();
        check_val("lat_cycle1", {127'h0, params_valid}, 128'h0);
        tick();
        check_val("lat_cycle2", {127'h0, params_valid}, 128'h1);
        repeat (3) advance_chirp();
        wait_seq_done();
        tick(); tick();
        check_val("sweep1_valid", {127'h0, params_valid}, 128'h0);
        check_val("sweep1_idx", {124'h0, profile_idx}, 128'h0);
        check_val("sweep1_count", {96'h0, sweep_count}, 128'(exp_sweeps));
        check_val("sweep1_hold", chirp_parameters_out, {32'h0, 32'h600, 32'h1, 32'h300});
        repeat (3) tick();
        check_val("no_restart", {127'h0, params_valid}, 128'h0);
        check_val("done_once", 128'(done_cnt), 128'h1);
        seq_enable = 1'b0;
        tick();

        // Looping over profiles 0..1
        seq_loop = 1'b1; seq_last = 4'd1;
        start_seq();
        repeat (5) advance_chirp();
        check_val("loop_count", {96'h0, sweep_count}, 128'(exp_sweeps));
        check_val("loop_no_done", 128'(done_cnt), 128'h1);

        // Write to the armed entry is deferred until its next load
        wr(1, 0, 32'h555);
        tick();
        check_val("armed_hold", chirp_parameters_out, {32'h0, 32'h600, 32'h1, 32'h200});
        check_val("armed_idx", {124'h0, profile_idx}, 128'h1);
        repeat (2) advance_chirp();

        // Disable while armed: chirp completes, then idle
        seq_enable = 1'b0;
        repeat (3) tick();
        check_val("dis_still_valid", {127'h0, params_valid}, 128'h1);
        check_val("dis_params", chirp_parameters_out, {32'h0, 32'h600, 32'h1, 32'h555});
        pulse_done();
        check_val("dis_idle_valid", {127'h0, params_valid}, 128'h0);
        tick();
        check_val("dis_idle_idx", {124'h0, profile_idx}, 128'h0);
        check_val("dis_sweep", {96'h0, sweep_count}, 128'(exp_sweeps));
        pulse_done();
        tick();
        check_val("idle_done_valid", {127'h0, params_valid}, 128'h0);
        check_val("idle_done_sweep", {96'h0, sweep_count}, 128'(exp_sweeps));
        check_val("idle_done_params", chirp_parameters_out, {32'h0, 32'h600, 32'h1, 32'h555});

        // Dropped writes and seq_last beyond the table
        wr(9, 0, 32'hDEAD);
        wr(8, 1, 32'hBEEF);
        wr(3, 3, 32'hBAD0);
        wr(4, 2, 32'h0777);
        seq_loop = 1'b0; seq_last = 4'd12;
        start_seq();
        repeat (8) advance_chirp();
        wait_seq_done();
        tick();
        check_val("wide_sweep", {96'h0, sweep_count}, 128'(exp_sweeps));
        check_val("wide_done", 128'(done_cnt), 128'h2);
        seq_enable = 1'b0;
        repeat (2) tick();
        check_val("sb_drained", 128'(sb.size()), 128'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
